// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache / main-memory subsystem.
package cache_pkg;
    typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, STORE} arb_state_t;
    localparam int MEM_LATENCY = 4;
    localparam int CACHE_WORDS = 8;
endpackage

// File: rtl/arb_owner_sel.sv
// arb_owner_sel: next memory owner chosen from IDLE; stores beat fills.
// CACHE_ARB_ROUND_ROBIN_EN: contending fills alternate via last_d_i, otherwise D-fill wins.
module arb_owner_sel
    import cache_pkg::*;
(
    input  logic       st_req_i,
    input  logic       i_busy_i,
    input  logic       d_busy_i,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    input  logic       last_d_i,
`endif
    output logic [1:0] next_state_o
);
    logic d_first;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    assign d_first = d_busy_i & (~i_busy_i | ~last_d_i);
`else
    assign d_first = d_busy_i;
`endif
    always_comb next_state_o = st_req_i ? STORE : d_first ? FILL_D : i_busy_i ? FILL_I : IDLE;
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single memory port between I-fill, D-fill and write-through stores.
// CACHE_ARB_ROUND_ROBIN_EN selects round-robin between contending fills.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_busy,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_busy,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic              st_ack,
    output logic              arb_err
);
    arb_state_t state_q, state_d;
    logic pending_q, pending_d, arb_err_q;
    logic [1:0] sel_state;
    logic busy;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last_d_q;
`endif

    arb_owner_sel u_sel (
        .st_req_i     (st_req),
        .i_busy_i     (i_busy),
        .d_busy_i     (d_busy),
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        .last_d_i     (last_d_q),
`endif
        .next_state_o (sel_state)
    );

    assign busy         = (state_q == FILL_I) ? i_busy : d_busy;
    assign i_grant      = state_q == FILL_I;
    assign d_grant      = state_q == FILL_D;
    assign i_data_valid = i_grant & pending_q & mem_data_valid;
    assign d_data_valid = d_grant & pending_q & mem_data_valid;
    assign arb_err      = arb_err_q;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        st_ack       = 1'b0;
        case (state_q)
            IDLE: state_d = arb_state_t'(sel_state);
            STORE: begin
                mem_en       = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = st_addr;
                mem_data_out = st_data;
                st_ack       = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                mem_en    = busy & ~pending_q;
                mem_addr  = mem_en ? (i_grant ? i_addr : d_addr) : '0;
                pending_d = mem_en | (pending_q & ~mem_data_valid);
                // a read in flight holds ownership even after the owner drops busy
                state_d   = (~busy & (~pending_q | mem_data_valid)) ? IDLE : state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            arb_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            arb_err_q <= arb_err_q | (mem_data_valid & ~pending_q);
        end
    end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)
            last_d_q <= 1'b0;
        else if (state_q == IDLE && (sel_state == FILL_I || sel_state == FILL_D))
            last_d_q <= sel_state == FILL_D;
    end
`endif
endmodule
